// File: rtl/sec_corr_arbiter.sv
// sec_corr_arbiter: round-robin time-sharing of one 32-bit SEC corrector.
// Optional SEC_CORR_ARBITER_MULTI_FLAG_EN adds rsp_multi and multi_cnt.
module sec_corr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*32-1:0]  req_data,
    input  logic [NREQ*8-1:0]   req_chk,
    input  logic [NREQ-1:0]     req_corr_en,
    output logic [NREQ-1:0]     req_ready,
    output logic [31:0]         sec_data,
    output logic [7:0]          sec_chk,
    output logic                sec_en,
    input  logic [31:0]         sec_corr_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_data,
    output logic                rsp_flip,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    err_cnt
`ifdef SEC_CORR_ARBITER_MULTI_FLAG_EN
    ,
    output logic                rsp_multi,
    output logic [CNT_W-1:0]    multi_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, win, idx;
    logic           found, grant, hs;
    logic           err_inc;
    logic [31:0]    diff;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        hs        = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    hs        = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst_n so an asserted reset never shows a grant pulse.
    assign req_ready = (grant && rst_n) ? (NREQ'(1) << win) : '0;

    // sec_data still holds the raw word during ISSUE, so it is the reference.
    assign diff = sec_corr_data ^ sec_data;

`ifdef SEC_CORR_ARBITER_MULTI_FLAG_EN
    assign err_inc = hs && rsp_flip && !rsp_multi;
`else
    assign err_inc = hs && rsp_flip;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sec_data  <= '0;
            sec_chk   <= '0;
            sec_en    <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flip  <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sec_data <= req_data[{win, 5'd0} +: 32];
                sec_chk  <= req_chk[{win, 3'd0} +: 8];
                sec_en   <= req_corr_en[win];
                rsp_id   <= win;
                ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            end
            if (state == ISSUE) begin
                rsp_data  <= sec_corr_data;
                rsp_flip  <= |diff;
                rsp_valid <= 1'b1;
            end
            if (hs) begin
                rsp_valid <= 1'b0;
                sec_en    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (err_inc && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

`ifdef SEC_CORR_ARBITER_MULTI_FLAG_EN
    // More than one bit set in diff means the corrector touched 2+ bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_multi <= 1'b0;
            multi_cnt <= '0;
        end else begin
            if (state == ISSUE)
                rsp_multi <= |(diff & (diff - 32'd1));
            if (cnt_clr)
                multi_cnt <= '0;
            else if (hs && rsp_multi && multi_cnt != CNT_MAX)
                multi_cnt <= multi_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sec_corr_arbiter.sv
// tb_sec_corr_arbiter: randomized bench with a transaction-level model
// and a behavioural syndrome-decoding SEC corrector.
module tb_sec_corr_arbiter;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int MAX = 15;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N*8-1:0]  req_chk;
    logic [N-1:0]    req_corr_en;
    logic [N-1:0]    req_ready;
    logic [31:0]     sec_data;
    logic [7:0]      sec_chk;
    logic            sec_en;
    logic [31:0]     sec_corr_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_flip;
    logic            cnt_clr;
    logic [CW-1:0]   err_cnt;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;
    int merr     = 0;

    logic [31:0] orig[N];
    logic [31:0] pd[N];
    logic [7:0]  pc[N];
    logic        pen[N];
    int          et[N];

    sec_corr_arbiter #(.NREQ(N), .IDW(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data),
        .req_chk(req_chk), .req_corr_en(req_corr_en),
        .req_ready(req_ready),
        .sec_data(sec_data), .sec_chk(sec_chk), .sec_en(sec_en),
        .sec_corr_data(sec_corr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flip(rsp_flip),
        .cnt_clr(cnt_clr), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] col(input int j);
        return 8'((j << 3) | 7);
    endfunction

    function automatic logic [7:0] enc(input logic [31:0] d);
        logic [7:0] c;
        c = '0;
        for (int j = 0; j < 32; j++)
            if (d[j]) c = c ^ col(j);
        return c;
    endfunction

    always_comb begin
        logic [7:0] syn;
        syn = sec_chk ^ enc(sec_data);
        sec_corr_data = sec_data;
        if (sec_en)
            for (int j = 0; j < 32; j++)
                if (syn == col(j)) sec_corr_data[j] = ~sec_data[j];
    end

    task automatic drive_payload();
        for (int i = 0; i < N; i++) begin
            req_data[32*i +: 32] = pd[i];
            req_chk[8*i +: 8]    = pc[i];
            req_corr_en[i]       = pen[i];
        end
    endtask

    task automatic clean_payload();
        for (int i = 0; i < N; i++) begin
            orig[i] = $urandom;
            pd[i]   = orig[i];
            pc[i]   = enc(orig[i]);
            pen[i]  = 1'b1;
            et[i]   = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        cnt_clr = 1'b0;
        clean_payload();
        drive_payload();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_flip, sec_en} !== 7'd0)
            $display("FAIL reset_ctl got=%b exp=0",
                     {req_ready, rsp_valid, rsp_flip, sec_en});
        checks++;
        if ({sec_data, sec_chk, rsp_data, rsp_id, err_cnt} !== 78'd0)
            $display("FAIL reset_data got=%h exp=0",
                     {sec_data, sec_chk, rsp_data, rsp_id, err_cnt});
        if ({req_ready, rsp_valid, rsp_flip, sec_en} !== 7'd0 ||
            {sec_data, sec_chk, rsp_data, rsp_id, err_cnt} !== 78'd0)
            failures++;
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        mptr = 0;
        merr = 0;
    endtask

    task automatic test_directed(input int r, input logic [31:0] d,
                                 input logic [31:0] good,
                                 input logic [31:0] expd, input logic expf);
        for (int i = 0; i < N; i++) begin
            pd[i] = '0; pc[i] = '0; pen[i] = 1'b0;
        end
        pd[r] = d; pc[r] = enc(good); pen[r] = 1'b1;
        @(negedge clk);
        req_valid = 4'(1 << r);
        drive_payload();
        #1;
        checks++;
        if (req_ready !== 4'(1 << r)) begin
            failures++;
            $display("FAIL dir_ready got=%b exp=%b", req_ready, 4'(1 << r));
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (sec_data !== d || sec_en !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL dir_sec got=%h/%b/%b exp=%h/1/0",
                     sec_data, sec_en, rsp_valid, d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(r) ||
            rsp_data !== expd || rsp_flip !== expf || err_cnt !== CW'(merr)) begin
            failures++;
            $display("FAIL dir_rsp got=%b/%0d/%h/%b/%0d exp=1/%0d/%h/%b/%0d",
                     rsp_valid, rsp_id, rsp_data, rsp_flip, err_cnt,
                     r, expd, expf, merr);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        mptr = (r + 1) % N;
        if (expf && merr < MAX) merr++;
        #1;
        checks++;
        if (err_cnt !== CW'(merr) || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL dir_cnt got=%0d/%b exp=%0d/0", err_cnt, rsp_valid, merr);
        end
    endtask

    // mode 0: random errors/enables; 1: forced data error; 2: as 1 plus cnt_clr
    task automatic test_random(input int n, input int mode,
                               input int smin, input int smax);
        logic [N-1:0] v;
        logic [31:0]  expd;
        logic         expf;
        int           w, stall, b;
        for (int k = 0; k < n; k++) begin
            v = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                orig[i] = $urandom;
                pd[i]   = orig[i];
                pc[i]   = enc(orig[i]);
                pen[i]  = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                et[i]   = (mode == 0) ? int'($urandom_range(0, 2)) : 1;
                if (et[i] == 1) begin
                    b = $urandom_range(0, 31);
                    pd[i][b] = ~pd[i][b];
                end else if (et[i] == 2) begin
                    b = $urandom_range(0, 7);
                    pc[i][b] = ~pc[i][b];
                end
            end
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && v[(mptr + i) % N]) w = (mptr + i) % N;
            expf = pen[w] && et[w] == 1;
            expd = expf ? orig[w] : pd[w];
            @(negedge clk);
            req_valid = v;
            drive_payload();
            #1;
            checks++;
            if (req_ready !== 4'(1 << w)) begin
                failures++;
                $display("FAIL rnd_grant got=%b exp=%b", req_ready, 4'(1 << w));
            end
            @(negedge clk);
            req_valid = '0;
            #1;
            checks++;
            if (req_ready !== '0 || sec_data !== pd[w] || sec_chk !== pc[w] ||
                sec_en !== pen[w] || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rnd_sec got=%b/%h/%h/%b exp=0/%h/%h/%b",
                         req_ready, sec_data, sec_chk, sec_en,
                         pd[w], pc[w], pen[w]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) ||
                rsp_data !== expd || rsp_flip !== expf) begin
                failures++;
                $display("FAIL rnd_rsp got=%b/%0d/%h/%b exp=1/%0d/%h/%b",
                         rsp_valid, rsp_id, rsp_data, rsp_flip, w, expd, expf);
            end
            stall = $urandom_range(smin, smax);
            for (int s = 0; s < stall; s++) begin
                req_valid = 4'($urandom_range(1, 15));
                #1;
                checks++;
                if (req_ready !== '0) begin
                    failures++;
                    $display("FAIL stall_ready got=%b exp=0", req_ready);
                end
                @(negedge clk);
                #1;
                checks++;
                if ({rsp_valid, rsp_id, rsp_data, rsp_flip} !==
                    {1'b1, 2'(w), expd, expf}) begin
                    failures++;
                    $display("FAIL stall_hold got=%b/%0d/%h/%b exp=1/%0d/%h/%b",
                             rsp_valid, rsp_id, rsp_data, rsp_flip, w, expd, expf);
                end
            end
            req_valid = '0;
            rsp_ready = 1'b1;
            cnt_clr = (mode == 2);
            @(negedge clk);
            rsp_ready = 1'b0;
            cnt_clr = 1'b0;
            mptr = (w + 1) % N;
            if (mode == 2) merr = 0;
            else if (expf && merr < MAX) merr++;
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || sec_en !== 1'b0 || err_cnt !== CW'(merr)) begin
                failures++;
                $display("FAIL rnd_hs got=%b/%b/%0d exp=0/0/%0d",
                         rsp_valid, sec_en, err_cnt, merr);
            end
        end
    endtask

    task automatic test_round_robin();
        int got, last, exp_w, g;
        clean_payload();
        drive_payload();
        rsp_ready = 1'b1;
        g = 0;
        last = -1;
        @(negedge clk);
        req_valid = '1;
        for (int c = 0; c < 20 && g < 5; c++) begin
            #1;
            if (req_ready !== '0) begin
                exp_w = mptr;
                checks++;
                if (req_ready !== 4'(1 << exp_w)) begin
                    failures++;
                    $display("FAIL rr_order got=%b exp=%b", req_ready, 4'(1 << exp_w));
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != 3) begin
                        failures++;
                        $display("FAIL rr_gap got=%0d exp=3", c - last);
                    end
                end
                last = c;
                mptr = (exp_w + 1) % N;
                g++;
            end
            if (g < 5) @(negedge clk);
        end
        checks++;
        if (g != 5) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=5", g);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        clean_payload();
        drive_payload();
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, sec_en, sec_data, sec_chk,
             rsp_data, rsp_id, rsp_flip, err_cnt} !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b/%b/%h/%0d exp=0",
                     req_ready, rsp_valid, sec_en, sec_data, err_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_glitch got=%b/%b exp=0/0", req_ready, rsp_valid);
        end
        req_valid = 4'b1010;
        rst_n = 1'b1;
        mptr = 0;
        merr = 0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_ptr got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== orig[1]) begin
            failures++;
            $display("FAIL mid_rsp got=%b/%0d/%h exp=1/1/%h",
                     rsp_valid, rsp_id, rsp_data, orig[1]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        mptr = 2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed(1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0);
        test_directed(0, 32'h1234_567C, 32'h1234_5678, 32'h1234_5678, 1'b1);
        test_round_robin();
        test_random(40, 0, 0, 3);
        test_random(2, 0, 5, 5);
        test_random(18, 1, 0, 1);
        test_random(1, 2, 0, 0);
        test_reset_mid();
        test_random(15, 0, 0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
